// File: rtl/spi_dac_pkg.sv
// Shared constants and types for the SPI DAC responder.
package spi_dac_pkg;

  localparam int FRAME_BITS_C = 24;
  localparam int DATA_BITS_C  = 16;

  // Field positions inside a frame: cmd[23:20], addr[19:16], data[15:0].
  localparam int CMD_LSB_C  = 20;
  localparam int CMD_W_C    = 4;
  localparam int ADDR_LSB_C = 16;
  localparam int ADDR_W_C   = 4;
  localparam int DATA_LSB_C = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    NOP          = 4'h0,
    WRITE        = 4'h1,
    UPDATE       = 4'h2,
    WRITE_UPDATE = 4'h3
  } cmd_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus one edge-detect flop for an asynchronous pin.
// The level output is the second synchronizer stage; rise/fall compare it
// against the third flop, so a pin edge is acted on three clocks later.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain and edge-detect history flop.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
      s3_q <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old
      // value; blocking here would collapse the chain into a single flop.
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/spi_dac_receiver.sv
// SPI responder modelling the DAC end of the DacWriter link. Oversamples the
// SPI pins in the clk_i domain, deserializes 24-bit MSB-first frames, decodes
// cmd/addr/data and holds the last written DAC code.
// Optional build macro: SPI_READBACK_EN (spi_miso_o replays the previous good
// frame); when undefined spi_miso_o is tied low.
module spi_dac_receiver
  import spi_dac_pkg::*;
#(
  parameter int         FRAME_BITS       = FRAME_BITS_C,
  parameter int         DATA_BITS        = DATA_BITS_C,
  parameter logic [3:0] CMD_WRITE_UPDATE = WRITE_UPDATE
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 spi_clk_i,
  input  logic                 spi_cs_ni,
  input  logic                 spi_mosi_i,
  input  logic                 dac_reset_ni,
  output logic                 spi_miso_o,
  output logic [3:0]           cmd_o,
  output logic [3:0]           addr_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic [DATA_BITS-1:0] dac_value_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  // Synchronized pin views.
  logic clk_lvl, clk_rise, clk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic dac_rst_lvl, dac_rst_rise, dac_rst_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_clk_i),
    .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_cs_ni),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_mosi_i),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // The DAC reset pin idles high so a chip reset never looks like a DAC reset.
  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_dac_rst (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(dac_reset_ni),
    .level_o(dac_rst_lvl), .rise_o(dac_rst_rise), .fall_o(dac_rst_fall)
  );

  // Only levels are needed for mosi and DAC reset, and the clock level is
  // never read; edges are the events of interest there.
  logic unused_sync;
  assign unused_sync = ^{clk_lvl, cs_lvl, mosi_rise, mosi_fall,
                         dac_rst_rise, dac_rst_fall, clk_fall};

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [3:0]             cmd_q, addr_q;
  logic [DATA_BITS-1:0]   data_q, dac_q;
  logic                   valid_q, err_q;
  logic                   start_frame;

  // A new frame may start from IDLE, or straight out of DONE when cs fell
  // during the completion cycle.
  assign start_frame = cs_fall && (state_q == IDLE || state_q == DONE);

  // Next shift-register and saturating bit-counter values for one SPI bit.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    shift_d = {shift_q[FRAME_BITS-2:0], mosi_lvl};
    cnt_d   = cnt_q;
    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
  end

  // Frame FSM with registered decode outputs and DAC code register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the shift register is reset along with the control state so
      // the decode fields never expose stale bits after a reset.
      shift_q <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      dac_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_frame) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        SHIFT: begin
          // cs rising wins over a coincident clock edge.
          if (cs_rise) begin
            if (cnt_q == CNT_FULL) begin
              state_q <= DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else if (clk_rise) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
          end
        end
        DONE: begin
          cmd_q   <= shift_q[CMD_LSB_C +: CMD_W_C];
          addr_q  <= shift_q[ADDR_LSB_C +: ADDR_W_C];
          data_q  <= shift_q[DATA_LSB_C +: DATA_BITS];
          valid_q <= 1'b1;
          if (shift_q[CMD_LSB_C +: CMD_W_C] == CMD_WRITE_UPDATE && dac_rst_lvl)
            dac_q <= shift_q[DATA_LSB_C +: DATA_BITS];
          if (start_frame) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shift_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // DAC reset pin overrides any load while it is held low.
      if (!dac_rst_lvl) dac_q <= '0;
    end
  end

  assign cmd_o       = cmd_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = err_q;
  assign dac_value_o = dac_q;
  assign busy_o      = (state_q == SHIFT);

`ifdef SPI_READBACK_EN
  logic [FRAME_BITS-1:0] rb_q, tx_q, rb_src;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic                  miso_q;

  // A frame completing in DONE is already the "previous" frame for a new
  // frame that starts in the same cycle.
  assign rb_src = (state_q == DONE) ? shift_q : rb_q;

  // Readback capture and MSB-first replay on falling SPI clock edges.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rb_q     <= '0;
      tx_q     <= '0;
      tx_cnt_q <= '0;
      miso_q   <= 1'b0;
    end else begin
      if (state_q == DONE) rb_q <= shift_q;
      if (start_frame) begin
        miso_q   <= rb_src[FRAME_BITS-1];
        tx_q     <= {rb_src[FRAME_BITS-2:0], 1'b0};
        tx_cnt_q <= CNT_W'(1);
      end else if (state_q == SHIFT && !cs_rise) begin
        if (clk_fall) begin
          if (tx_cnt_q < CNT_FULL) begin
            miso_q   <= tx_q[FRAME_BITS-1];
            tx_q     <= {tx_q[FRAME_BITS-2:0], 1'b0};
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end else begin
            miso_q <= 1'b0;
          end
        end
      end else begin
        miso_q <= 1'b0;
      end
    end
  end

  assign spi_miso_o = miso_q;
`else
  assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Self-checking bench for spi_dac_receiver: directed frames with literal
// expectations, then randomized frames checked every cycle against a
// transaction-level model of the responder.
module tb_spi_dac_receiver;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        spi_clk_i = 1'b0;
  logic        spi_cs_ni = 1'b1;
  logic        spi_mosi_i = 1'b0;
  logic        dac_reset_ni = 1'b1;
  logic        spi_miso_o;
  logic [3:0]  cmd_o, addr_o;
  logic [15:0] data_o, dac_value_o;
  logic        valid_o, frame_err_o, busy_o;

  spi_dac_receiver dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .spi_clk_i(spi_clk_i),
    .spi_cs_ni(spi_cs_ni), .spi_mosi_i(spi_mosi_i), .dac_reset_ni(dac_reset_ni),
    .spi_miso_o(spi_miso_o), .cmd_o(cmd_o), .addr_o(addr_o), .data_o(data_o),
    .valid_o(valid_o), .dac_value_o(dac_value_o), .frame_err_o(frame_err_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: scheduled events in absolute clock counts.
  logic [3:0]  exp_cmd = '0, exp_addr = '0;
  logic [15:0] exp_data = '0, exp_dac = '0;
  logic [23:0] exp_rb = '0;
  logic        exp_busy = 1'b0;
  logic        dac_eff = 1'b1, dac_lvl = 1'b1;
  logic [23:0] done_frame = '0;
  int          done_cyc = -1, err_cyc = -1, busy_on = -1, busy_off = -1;
  int          dac_cyc = -1, last_rise = 0;

  // Per-cycle comparison of every output against the model.
  always @(posedge clk_i) begin
    logic ev, ee;
    cyc++;
    #1;
    ev = 1'b0;
    ee = 1'b0;
    if (!reset_ni) begin
      exp_cmd = '0; exp_addr = '0; exp_data = '0; exp_dac = '0; exp_rb = '0;
      exp_busy = 1'b0; dac_eff = 1'b1;
      done_cyc = -1; err_cyc = -1; busy_on = -1; busy_off = -1; dac_cyc = -1;
    end else begin
      if (cyc == busy_on)  exp_busy = 1'b1;
      if (cyc == busy_off) exp_busy = 1'b0;
      if (cyc == dac_cyc)  dac_eff = dac_lvl;
      if (!dac_eff) exp_dac = '0;
      ee = (cyc == err_cyc);
      ev = (cyc == done_cyc);
      if (ev) begin
        exp_cmd  = done_frame[23:20];
        exp_addr = done_frame[19:16];
        exp_data = done_frame[15:0];
        exp_rb   = done_frame;
        if (done_frame[23:20] == 4'h3 && dac_eff) exp_dac = done_frame[15:0];
      end
    end
    check("valid", {31'd0, valid_o}, {31'd0, ev});
    check("frame_err", {31'd0, frame_err_o}, {31'd0, ee});
    check("busy", {31'd0, busy_o}, {31'd0, exp_busy});
    check("cmd", {28'd0, cmd_o}, {28'd0, exp_cmd});
    check("addr", {28'd0, addr_o}, {28'd0, exp_addr});
    check("data", {16'd0, data_o}, {16'd0, exp_data});
    check("dac_value", {16'd0, dac_value_o}, {16'd0, exp_dac});
`ifdef SPI_READBACK_EN
    if (!exp_busy) check("miso_idle", {31'd0, spi_miso_o}, 32'd0);
`else
    check("miso_tied", {31'd0, spi_miso_o}, 32'd0);
`endif
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Drive one frame of nbits (frame[nbits-1] first); abort_at >= 0 applies
  // the chip reset just before that bit's rising clock edge.
  task automatic send_frame(input logic [31:0] frame, input int nbits,
                            input int half, input int abort_at);
    @(negedge clk_i);
    spi_cs_ni = 1'b0;
    busy_on = cyc + 3;
    idle(half);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = frame[nbits-1-i];
      idle(half);
      if (i == abort_at) begin
        reset_ni = 1'b0;
        spi_clk_i = 1'b0;
        spi_cs_ni = 1'b1;
        spi_mosi_i = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy_o}, 32'd0);
        check("async_rst_data", {16'd0, data_o}, 32'd0);
        check("async_rst_dac", {16'd0, dac_value_o}, 32'd0);
        check("async_rst_cmd", {28'd0, cmd_o}, 32'd0);
        idle(3);
        reset_ni = 1'b1;
        return;
      end
`ifdef SPI_READBACK_EN
      check("miso_bit", {31'd0, spi_miso_o}, {31'd0, (i < 24) ? exp_rb[23-i] : 1'b0});
`endif
      spi_clk_i = 1'b1;
      idle(half);
      spi_clk_i = 1'b0;
    end
    spi_mosi_i = 1'b0;
    idle(half);
    spi_cs_ni = 1'b1;
    last_rise = cyc;
    busy_off = cyc + 3;
    if (nbits == 24) begin
      done_frame = frame[23:0];
      done_cyc = cyc + 4;
    end else begin
      err_cyc = cyc + 3;
    end
  endtask

  // Bounded watch for the completion pulses after a cs rising edge.
  task automatic wait_event(output int dly, output logic sv, output logic se);
    dly = -1;
    sv = 1'b0;
    se = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (valid_o && !sv) begin sv = 1'b1; dly = cyc - last_rise; end
      if (frame_err_o) se = 1'b1;
    end
  endtask

  task automatic set_dac(input logic v);
    @(negedge clk_i);
    dac_reset_ni = v;
    dac_lvl = v;
    dac_cyc = cyc + 3;
    idle(5);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int   dly;
    logic sv, se;
    logic [31:0] fr;
    int   nb, hf;

    idle(5);
    reset_ni = 1'b1;
    idle(2);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_dac", {16'd0, dac_value_o}, 32'd0);

    // Good write-update frame.
    send_frame(32'h0030_7FFF, 24, 5, -1);
    wait_event(dly, sv, se);
    check("good_valid_seen", {31'd0, sv}, 32'd1);
    check("good_latency", dly, 32'd4);
    check("good_no_err", {31'd0, se}, 32'd0);
    check("good_cmd", {28'd0, cmd_o}, 32'd3);
    check("good_addr", {28'd0, addr_o}, 32'd0);
    check("good_data", {16'd0, data_o}, 32'h7FFF);
    check("good_dac", {16'd0, dac_value_o}, 32'h7FFF);

    // Write without update leaves the DAC code alone.
    send_frame(32'h0010_8000, 24, 5, -1);
    wait_event(dly, sv, se);
    check("wr_valid_seen", {31'd0, sv}, 32'd1);
    check("wr_data", {16'd0, data_o}, 32'h8000);
    check("wr_dac", {16'd0, dac_value_o}, 32'h7FFF);

    // Short and long frames.
    send_frame(32'h0012_3456, 23, 4, -1);
    wait_event(dly, sv, se);
    check("short_err", {31'd0, se}, 32'd1);
    check("short_no_valid", {31'd0, sv}, 32'd0);
    check("short_data_kept", {16'd0, data_o}, 32'h8000);
    send_frame(32'h0123_4567, 25, 3, -1);
    wait_event(dly, sv, se);
    check("long_err", {31'd0, se}, 32'd1);
    check("long_no_valid", {31'd0, sv}, 32'd0);
    check("long_dac_kept", {16'd0, dac_value_o}, 32'h7FFF);

    // DAC reset held low: frame decodes, DAC stays at zero.
    set_dac(1'b0);
    check("dacrst_zero", {16'd0, dac_value_o}, 32'd0);
    send_frame(32'h0030_1234, 24, 5, -1);
    wait_event(dly, sv, se);
    check("dacrst_data", {16'd0, data_o}, 32'h1234);
    check("dacrst_dac", {16'd0, dac_value_o}, 32'd0);
    set_dac(1'b1);

    // Readback pair: the second frame replays 24'h30ABCD.
    send_frame(32'h0030_ABCD, 24, 5, -1);
    idle(6);
    send_frame(32'h0021_0F0F, 24, 4, -1);
    wait_event(dly, sv, se);
    check("rb2_addr", {28'd0, addr_o}, 32'd1);
    check("rb2_dac", {16'd0, dac_value_o}, 32'hABCD);

    // Chip reset mid-frame, then a clean frame.
    send_frame(32'h0030_9999, 24, 5, 12);
    idle(4);
    send_frame(32'h0035_5A5A, 24, 5, -1);
    wait_event(dly, sv, se);
    check("post_rst_valid", {31'd0, sv}, 32'd1);
    check("post_rst_addr", {28'd0, addr_o}, 32'd5);
    check("post_rst_dac", {16'd0, dac_value_o}, 32'h5A5A);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      fr = $urandom;
      if ($urandom_range(0, 1) == 0) fr[23:20] = 4'h3;
      case ($urandom_range(0, 9))
        0:       nb = 23;
        1:       nb = 25;
        default: nb = 24;
      endcase
      hf = $urandom_range(3, 6);
      send_frame(fr, nb, hf, -1);
      idle(6);
      // Clock toggles with cs high must be ignored.
      if ($urandom_range(0, 3) == 0) begin
        spi_clk_i = 1'b1; idle(4);
        spi_clk_i = 1'b0; idle(4);
      end
      if ($urandom_range(0, 7) == 0) set_dac(~dac_reset_ni);
    end
    if (!dac_reset_ni) set_dac(1'b1);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
